cordic_sched: RTL

Round-robin scheduler that shares one bit-serial CORDIC rotation engine among NREQ requesters. It accepts operand triples (x0, y0, z0) over per-requester valid/ready handshakes and launches the engine with a one-cycle start pulse. It then waits for engine completion, or a timeout, and returns the result tagged with the requester index on a single response channel. It sits between the client blocks and the CORDIC core and is the only driver of the core's start and operand inputs.

---
 rtl/cordic_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/cordic_sched.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// ----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC scheduling slice: default operand width,
// default WAIT timeout, the scheduler state encoding and the helper that
// sizes requester-index fields.
// ----------------------------------------------------------------------------
package cordic_pkg;

    localparam int W_DEF       = 16;   // operand/result width, same Q-format as the core
    localparam int NREQ_DEF    = 4;    // default number of requesters
    localparam int TIMEOUT_DEF = 512;  // WAIT cycles before abort; core nominally needs 13*18

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } sched_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Scans the request vector starting
// at index ptr and wrapping modulo NREQ; the first requester found wins.
// Reusable by any scheduler that shares one resource among NREQ clients.
//
// Ports
//   req        in   NREQ  request vector
//   ptr        in   IDW   highest-priority index for this cycle (must be < NREQ)
//   grant      out  NREQ  one-hot grant (all zero when no request)
//   grant_idx  out  IDW   binary index of the granted requester
//   any        out  1     at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter
    import cordic_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    // Candidate index for scan position i: (ptr + i) mod NREQ. Works for
    // non-power-of-two NREQ because ptr is always below NREQ.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    logic [IDW-1:0] cand [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cand[i] = wrap_idx(ptr, i);
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the scan; a path that
        // leaves one unassigned would infer a latch.
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[cand[i]]) begin
                any            = 1'b1;
                grant[cand[i]] = 1'b1;
                grant_idx      = cand[i];
            end
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// ----------------------------------------------------------------------------
// cordic_sched
// Round-robin scheduler sharing one bit-serial CORDIC rotation engine among
// NREQ requesters. One transaction is in flight at a time: a request is
// granted in IDLE, the engine is launched with a one-cycle eng_start pulse,
// the scheduler waits for eng_done (or a timeout) and then presents the
// result, tagged with the requester index, on the response channel.
//
// Ports
//   clk, rst                   clock; synchronous active-high reset
//   req_valid / req_ready      per-requester handshake (req_ready one-hot or 0)
//   req_x0, req_y0, req_z0     flattened operands, requester i at [i*W +: W]
//   rsp_valid / rsp_ready      response handshake
//   rsp_id                     requester index of the response
//   rsp_x, rsp_y               rotated vector (0 on timeout)
//   rsp_err                    response aborted by timeout
//   eng_start                  one-cycle launch pulse to the core
//   eng_x0, eng_y0, eng_z0     operands to the core, held from LAUNCH on
//   eng_done, eng_x, eng_y     core completion level and result
// ----------------------------------------------------------------------------
module cordic_sched
    import cordic_pkg::*;
#(
    parameter  int NREQ    = NREQ_DEF,
    parameter  int W       = W_DEF,
    parameter  int TIMEOUT = TIMEOUT_DEF,
    localparam int IDW     = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x0,
    input  logic [NREQ*W-1:0] req_y0,
    input  logic [NREQ*W-1:0] req_z0,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_x,
    output logic [W-1:0]      rsp_y,
    output logic              rsp_err,

    output logic              eng_start,
    output logic [W-1:0]      eng_x0,
    output logic [W-1:0]      eng_y0,
    output logic [W-1:0]      eng_z0,
    input  logic              eng_done,
    input  logic [W-1:0]      eng_x,
    input  logic [W-1:0]      eng_y
);

    // Counter must hold TIMEOUT-1.
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    sched_state_t    state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  cur_id;
    logic [CW-1:0]   cnt;

    logic [NREQ-1:0] arb_grant;
    logic [IDW-1:0]  arb_idx;
    logic            arb_any;
    logic            grant_now;

    logic [W-1:0]    sel_x0;
    logic [W-1:0]    sel_y0;
    logic [W-1:0]    sel_z0;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Grants happen only in IDLE. rst is folded in so no requester sees an
    // accept during a reset cycle (the registers will not capture it).
    assign grant_now = (state == IDLE) && arb_any && !rst;
    assign req_ready = grant_now ? arb_grant : '0;

    always_comb begin
        sel_x0 = req_x0[int'(arb_idx)*W +: W];
        sel_y0 = req_y0[int'(arb_idx)*W +: W];
        sel_z0 = req_z0[int'(arb_idx)*W +: W];
    end

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] idx);
        return (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // NOTE: all state here is sequential and uses non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_id    <= '0;
            cnt       <= '0;
            eng_start <= 1'b0;
            eng_x0    <= '0;
            eng_y0    <= '0;
            eng_z0    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_x     <= '0;
            rsp_y     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            // eng_start is set only on the IDLE->LAUNCH edge, so it is high
            // for the LAUNCH cycle alone.
            eng_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_now) begin
                        eng_x0    <= sel_x0;
                        eng_y0    <= sel_y0;
                        eng_z0    <= sel_z0;
                        cur_id    <= arb_idx;
                        rr_ptr    <= next_ptr(arb_idx);
                        eng_start <= 1'b1;
                        state     <= LAUNCH;
                    end
                end

                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end

                WAIT: begin
                    // eng_done is only looked at here; the core cleared any
                    // level left from a previous run on the eng_start edge.
                    // Done takes precedence over a coincident timeout.
                    if (eng_done) begin
                        rsp_x     <= eng_x;
                        rsp_y     <= eng_y;
                        rsp_err   <= 1'b0;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_x     <= '0;
                        rsp_y     <= '0;
                        rsp_err   <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
